// File: rtl/vtc_pkg.sv
// Shared definitions for the video timing controller: sync-bus bit positions,
// FSM state encoding and the raster total helper.
package vtc_pkg;

  localparam int SYNC_VS = 26;
  localparam int SYNC_HS = 25;
  localparam int SYNC_DE = 24;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int raster_total(input int active, input int blank);
    return active + blank;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Horizontal/vertical raster position counter pair with synchronous clear,
// advance enable and a flag marking the final cycle of the frame.
module raster_counter #(
  parameter int H_TOTAL = 1296,
  parameter int V_TOTAL = 724,
  parameter int HW      = $clog2(H_TOTAL),
  parameter int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          last
);

  localparam logic [HW-1:0] H_MAX = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_MAX = VW'(V_TOTAL - 1);

  logic h_wrap;

  assign h_wrap = (h_cnt == H_MAX);
  assign last   = h_wrap && (v_cnt == V_MAX);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (enable) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// Frame-timing controller: sequences frames with leading horizontal/vertical
// blanking and drives the registered frame-start / line-start / data-enable bus.
module video_timing_ctrl
  import vtc_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 4,
  parameter int FCNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic [FCNT_W-1:0]           num_frames,
  output logic [26:24]                Synco,
  output logic [$clog2(H_ACTIVE)-1:0] pix_x,
  output logic [$clog2(V_ACTIVE)-1:0] pix_y,
  output logic                        frame_done,
  output logic [FCNT_W-1:0]           frame_cnt,
  output logic                        busy
);

  localparam int H_TOTAL = raster_total(H_ACTIVE, H_BLANK);
  localparam int V_TOTAL = raster_total(V_ACTIVE, V_BLANK);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PXW     = $clog2(H_ACTIVE);
  localparam int PYW     = $clog2(V_ACTIVE);

  state_t            state_q, state_d;
  logic              clear, enable, frame_end;
  logic              stop_pend;
  logic [FCNT_W-1:0] num_frames_q;
  logic [FCNT_W-1:0] frame_cnt_next;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic              last;
  logic              de;
  logic [HW-1:0]     h_off;
  logic [VW-1:0]     v_off;

  raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .HW      (HW),
    .VW      (VW)
  ) u_raster (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .enable (enable),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .last   (last)
  );

  assign frame_cnt_next = frame_cnt + FCNT_W'(1);
  assign busy           = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A stop seen on the final cycle itself ends the run at this boundary.
  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    enable    = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        enable = 1'b1;
        if (last) begin
          frame_end = 1'b1;
          if (stop_pend || stop ||
              ((num_frames_q != '0) && (frame_cnt_next == num_frames_q)))
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_frames_q <= '0;
      frame_cnt    <= '0;
      stop_pend    <= 1'b0;
    end else if (clear) begin
      num_frames_q <= num_frames;
      frame_cnt    <= '0;
      stop_pend    <= 1'b0;
    end else if (state_q == RUN) begin
      if (frame_end) frame_cnt <= frame_cnt_next;
      if (frame_end && (state_d == IDLE)) stop_pend <= 1'b0;
      else if (stop)                      stop_pend <= 1'b1;
    end
  end

  assign de    = (h_cnt >= HW'(H_BLANK)) && (v_cnt >= VW'(V_BLANK));
  assign h_off = h_cnt - HW'(H_BLANK);
  assign v_off = v_cnt - VW'(V_BLANK);

  // Outputs lag the counters by one cycle, so the last frame drains after busy falls.
  always_ff @(posedge clk) begin
    if (rst || (state_q != RUN)) begin
      Synco      <= 3'b000;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      Synco[SYNC_VS] <= (h_cnt == '0) && (v_cnt == '0);
      Synco[SYNC_HS] <= (h_cnt == '0);
      Synco[SYNC_DE] <= de;
      pix_x          <= de ? h_off[PXW-1:0] : '0;
      pix_y          <= de ? v_off[PYW-1:0] : '0;
      frame_done     <= last;
    end
  end

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
- Frame-timing controller that drives the 3-bit sync bus Synci[26:24] consumed by the image pixel source and downstream image-processing blocks (bit 26 = frame start, bit 25 = line start, bit 24 = data enable).
- Sequences a configurable number of frames (or runs continuously) with programmable horizontal and vertical blanking.
- Reports active-pixel coordinates, frame completion and busy status to the testbench/top level.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines per frame
- H_BLANK, 16, blanking cycles at the start of each line (must be >=1)
- V_BLANK, 4, blanking lines at the start of each frame (must be >=1)
- FCNT_W, 16, width of the frame-count fields

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle start request
- stop  in  1  one-cycle graceful stop request
- num_frames  in  FCNT_W  frames to run; 0 = continuous; sampled on accepted start
- Synco  out  [26:24]  sync bus: [26] frame start, [25] line start, [24] data enable
- pix_x  out  $clog2(H_ACTIVE)  active column, valid when Synco[24]=1, else 0
- pix_y  out  $clog2(V_ACTIVE)  active row, valid when Synco[24]=1, else 0
- frame_done  out  1  one-cycle pulse on the last cycle of each frame
- frame_cnt  out  FCNT_W  frames completed since the last accepted start
- busy  out  1  high while state is RUN

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; h_cnt=v_cnt=0; Synco=3'b000; pix_x=pix_y=0; frame_done=0; frame_cnt=0; busy=0; stop_pend=0.
- Reset mid-frame aborts immediately. No partial frame is completed.
- Totals: H_TOTAL=H_ACTIVE+H_BLANK; V_TOTAL=V_ACTIVE+V_BLANK.
- Counters: h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps, and wraps 0..V_TOTAL-1. Counter widths are $clog2 of the totals.
- FSM states: IDLE, RUN.
  - IDLE + start: go to RUN; latch num_frames; clear frame_cnt; set h_cnt=v_cnt=0.
  - IDLE + stop: ignored.
  - RUN + start: ignored.
  - RUN + stop: set stop_pend.
  - RUN, last frame cycle (h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1):
    - increment frame_cnt (wraps at 2^FCNT_W);
    - if stop_pend, or num_frames!=0 and frame_cnt+1==num_frames: go to IDLE and clear stop_pend;
    - otherwise wrap and continue.
  - start and stop in the same cycle: in IDLE, start wins; in RUN, stop is taken.
  - stop arriving on the last frame cycle: takes effect at that boundary (no extra frame).
- Output decode (registered, one cycle after the counter state; Synco is 0 whenever the state is not RUN):
  - Synco[26] = (h_cnt==0 && v_cnt==0)
  - Synco[25] = (h_cnt==0)
  - Synco[24] = (h_cnt>=H_BLANK && v_cnt>=V_BLANK)
  - pix_x = h_cnt-H_BLANK and pix_y = v_cnt-V_BLANK when DE, else 0
  - frame_done is aligned with the last-cycle decode.
- Latency: start accepted at edge t gives RUN at t+1, and Synco[26]=1 on the cycle after edge t+2.
  - Synco[26] and Synco[24] are never high together.
  - Exactly H_ACTIVE*V_ACTIVE DE cycles per frame.
- busy falls on the edge that enters IDLE. The final frame's registered outputs, including frame_done, still drain one cycle later.

Decomposition:
- Shared package vtc_pkg: SYNC_VS=26, SYNC_HS=25, SYNC_DE=24 bit-index constants; state enum {IDLE, RUN}; function for H_TOTAL/V_TOTAL.
- One sub-module, raster_counter: the h/v counter pair with a clear input, an enable input and a last-cycle flag.

Test Plan:
- Params H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1; start with num_frames=1 -> one 24-cycle frame: Synco[26] once, Synco[25] 4 times, 12 DE cycles with pix_x 0..3 and pix_y 0..2; frame_done once; frame_cnt=1; busy low afterwards.
- num_frames=0; stop pulsed at cycle 30 of the run -> second frame completes; frame_cnt=2; IDLE at the end of cycle 48.
- start and stop in the same cycle while IDLE -> run starts, stop is ignored. start pulsed during RUN -> no restart, counters undisturbed.
- num_frames=3 -> three back-to-back frames with no gap cycles; frame_done pulses at output cycles 24, 48 and 72 after the first Synco[26].
- rst asserted at mid-frame cycle 10 -> all outputs 0 on the next cycle. A new start then yields a clean frame beginning with Synco[26].
- Full-size defaults, 1 frame -> exactly 921600 DE cycles; last pix_x=1279, last pix_y=719.
